// File: rtl/sr_instr_encoder_if.sv
// ============================================================================
//  Module      : sr_instr_encoder_if
//  Description : Request/response bundle of the schoolRISCV instruction
//                encoder. The request side carries symbolic instructions and
//                the output side carries machine words with word addresses.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sr_instr_encoder_if #(
    parameter int ADDR_W = 10
) ();
    logic              req_valid;
    logic              req_ready;
    logic [3:0]        req_op;
    logic [4:0]        req_rd;
    logic [4:0]        req_rs1;
    logic [4:0]        req_rs2;
    logic [31:0]       req_imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;
    logic              err;

    // Front end / memory-writer side
    modport master (
        output req_valid, req_op, req_rd, req_rs1, req_rs2, req_imm, out_ready,
        input  req_ready, out_valid, out_instr, out_addr, err
    );

    // Encoder side
    modport slave (
        input  req_valid, req_op, req_rd, req_rs1, req_rs2, req_imm, out_ready,
        output req_ready, out_valid, out_instr, out_addr, err
    );
endinterface

`default_nettype wire

// File: rtl/sr_instr_encoder.sv
// ============================================================================
//  Module      : sr_instr_encoder
//  Description : Encodes symbolic RV32I requests (ADD, OR, SRL, SLTU, SUB,
//                ADDI, LUI, BEQ, BNE, JAL) into machine words tagged with a
//                wrapping word address. Define SR_ENC_LI_EN to enable the
//                LI pseudo-instruction (one or two words).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sr_instr_encoder #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    sr_instr_encoder_if.slave bus
);

    localparam logic [6:0] OPC_R   = 7'b0110011;
    localparam logic [6:0] OPC_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI = 7'b0110111;
    localparam logic [6:0] OPC_BR  = 7'b1100011;
    localparam logic [6:0] OPC_JAL = 7'b1101111;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_SRL  = 4'd2;
    localparam logic [3:0] OP_SLTU = 4'd3;
    localparam logic [3:0] OP_SUB  = 4'd4;
    localparam logic [3:0] OP_ADDI = 4'd5;
    localparam logic [3:0] OP_LUI  = 4'd6;
    localparam logic [3:0] OP_BEQ  = 4'd7;
    localparam logic [3:0] OP_BNE  = 4'd8;
    localparam logic [3:0] OP_JAL  = 4'd9;
`ifdef SR_ENC_LI_EN
    localparam logic [3:0] OP_LI   = 4'd10;
`endif

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

`ifdef SR_ENC_LI_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EMIT  = 2'd1,
        EMIT2 = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EMIT  = 2'd1
    } state_t;
`endif

    state_t            state;
    logic              out_valid_q;
    logic [31:0]       instr_q;
    logic [ADDR_W-1:0] addr_q;
    logic              err_q;
`ifdef SR_ENC_LI_EN
    logic              pend_q;        // held LUI still owes its ADDI
    logic [31:0]       pend_instr_q;  // the owed ADDI word
`endif

    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        br_range_ok;
    logic        jal_range_ok;
    logic [31:0] enc_word;
    logic        enc_legal;
`ifdef SR_ENC_LI_EN
    logic [31:0] li_sum;
    logic        li_small;
    logic [31:0] enc_second;
    logic        enc_two;
`endif
    logic        req_ready;
    logic        accept;
    logic        handshake;

    assign imm = bus.req_imm;
    assign rd  = bus.req_rd;
    assign rs1 = bus.req_rs1;
    assign rs2 = bus.req_rs2;

    // An offset fits the signed field when all bits above the field's sign
    // bit agree with it, i.e. the upper slice is all zeros or all ones.
    assign br_range_ok  = (&imm[31:12]) | ~(|imm[31:12]);
    assign jal_range_ok = (&imm[31:20]) | ~(|imm[31:20]);

    // Combinational encoder: machine word and legality for the current request
    always_comb begin
        enc_word  = 32'd0;
        enc_legal = 1'b0;
`ifdef SR_ENC_LI_EN
        li_sum     = imm + 32'h0000_0800;
        li_small   = (&imm[31:11]) | ~(|imm[31:11]);
        enc_second = {imm[11:0], rd, 3'b000, rd, OPC_IMM};
        enc_two    = 1'b0;
`endif
        case (bus.req_op)
            OP_ADD:  begin enc_word = {7'b0000000, rs2, rs1, 3'b000, rd, OPC_R}; enc_legal = 1'b1; end
            OP_OR:   begin enc_word = {7'b0000000, rs2, rs1, 3'b110, rd, OPC_R}; enc_legal = 1'b1; end
            OP_SRL:  begin enc_word = {7'b0000000, rs2, rs1, 3'b101, rd, OPC_R}; enc_legal = 1'b1; end
            OP_SLTU: begin enc_word = {7'b0000000, rs2, rs1, 3'b011, rd, OPC_R}; enc_legal = 1'b1; end
            OP_SUB:  begin enc_word = {7'b0100000, rs2, rs1, 3'b000, rd, OPC_R}; enc_legal = 1'b1; end
            OP_ADDI: begin enc_word = {imm[11:0], rs1, 3'b000, rd, OPC_IMM}; enc_legal = 1'b1; end
            OP_LUI:  begin enc_word = {imm[31:12], rd, OPC_LUI}; enc_legal = 1'b1; end
            OP_BEQ, OP_BNE: begin
                enc_word  = {imm[12], imm[10:5], rs2, rs1, 2'b00, (bus.req_op == OP_BNE),
                             imm[4:1], imm[11], OPC_BR};
                enc_legal = br_range_ok & ~imm[0];
            end
            OP_JAL: begin
                enc_word  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
                enc_legal = jal_range_ok & ~imm[0];
            end
`ifdef SR_ENC_LI_EN
            OP_LI: begin
                enc_legal = 1'b1;
                if (li_small) begin
                    enc_word = {imm[11:0], 5'd0, 3'b000, rd, OPC_IMM};
                end else begin
                    // hi is rounded so that the sign-extended lo lands exactly
                    enc_word = {li_sum[31:12], rd, OPC_LUI};
                    enc_two  = |imm[11:0];
                end
            end
`endif
            default: begin
                enc_word  = 32'd0;
                enc_legal = 1'b0;
            end
        endcase
    end

    // Accept only when the output register is free or draining this cycle,
    // and never while an LI still has its second word to deliver.
`ifdef SR_ENC_LI_EN
    assign req_ready = rst_n & (~out_valid_q | bus.out_ready) & (state != EMIT2) & ~pend_q;
`else
    assign req_ready = rst_n & (~out_valid_q | bus.out_ready);
`endif
    assign accept    = bus.req_valid & req_ready;
    assign handshake = out_valid_q & bus.out_ready;

    // Output-register FSM: load accepted words, drain on handshake, feed LI tail
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            out_valid_q  <= 1'b0;
            instr_q      <= 32'd0;
            addr_q       <= '0;
            err_q        <= 1'b0;
`ifdef SR_ENC_LI_EN
            pend_q       <= 1'b0;
            pend_instr_q <= 32'd0;
`endif
        end else begin
            err_q <= 1'b0;
            if (handshake) begin
                addr_q <= addr_q + ADDR_ONE;
            end
            case (state)
                IDLE, EMIT: begin
                    if (accept) begin
                        if (enc_legal) begin
                            out_valid_q  <= 1'b1;
                            instr_q      <= enc_word;
                            state        <= EMIT;
`ifdef SR_ENC_LI_EN
                            pend_q       <= enc_two;
                            pend_instr_q <= enc_second;
`endif
                        end else begin
                            out_valid_q <= 1'b0;
                            err_q       <= 1'b1;
                            state       <= IDLE;
                        end
                    end else if (handshake) begin
                        out_valid_q <= 1'b0;
`ifdef SR_ENC_LI_EN
                        state       <= pend_q ? EMIT2 : IDLE;
`else
                        state       <= IDLE;
`endif
                    end
                end
`ifdef SR_ENC_LI_EN
                EMIT2: begin
                    instr_q     <= pend_instr_q;
                    out_valid_q <= 1'b1;
                    pend_q      <= 1'b0;
                    state       <= EMIT;
                end
`endif
                default: begin
                    out_valid_q <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_instr = instr_q;
    assign bus.out_addr  = addr_q;
    assign bus.err       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_sr_instr_encoder.sv
// ============================================================================
//  Module      : tb_sr_instr_encoder
//  Description : Self-checking bench for sr_instr_encoder with a behavioural
//                RV32I encoding model and a word/address scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sr_instr_encoder;

    localparam int ADDR_W = 2;
`ifdef SR_ENC_LI_EN
    localparam bit LI_EN = 1'b1;
`else
    localparam bit LI_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sr_instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();
    sr_instr_encoder #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;
    int seen  = 0;
    int exp_next = 0;
    int exp_err  = 0;
    bit rand_bp  = 1'b0;

    logic [31:0]       exp_instr [$];
    logic [ADDR_W-1:0] exp_addr  [$];
    logic [31:0]       obs_instr [$];
    logic [ADDR_W-1:0] obs_addr  [$];
    int                obs_err = 0;

    int bl [0:16] = '{-4096, 4094, 4096, -4098, 4095, -1048576, 1048574, 1048576,
                      -1048578, -2048, 2047, 2048, -2049, 0, 32'h12345FFF, 32'h1000, -2047};

    // Record every word that actually transfers and every error pulse
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            obs_instr.push_back(bus.out_instr);
            obs_addr.push_back(bus.out_addr);
        end
        if (rst_n && bus.err) obs_err++;
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] f_addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [31:0] imm);
        return ((imm & 32'hFFF) << 20) | (32'(rs1) << 15) | (32'(rd) << 7) | 32'h13;
    endfunction

    function automatic logic [31:0] f_lui(input logic [4:0] rd, input logic [31:0] upper20);
        return (upper20 << 12) | (32'(rd) << 7) | 32'h37;
    endfunction

    task automatic push_word(input logic [31:0] w);
        exp_instr.push_back(w);
        exp_addr.push_back(ADDR_W'(exp_next));
        exp_next = (exp_next + 1) % (1 << ADDR_W);
    endtask

    task automatic model(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [31:0] imm);
        int s;
        int f3;
        logic [31:0] w;
        s = int'($signed(imm));
        if (op <= 4'd4) begin
            f3 = (op == 4'd1) ? 6 : (op == 4'd2) ? 5 : (op == 4'd3) ? 3 : 0;
            w = ((op == 4'd4) ? 32'h4000_0000 : 32'h0) | (32'(rs2) << 20) | (32'(rs1) << 15)
                | (32'(f3) << 12) | (32'(rd) << 7) | 32'h33;
            push_word(w);
        end else if (op == 4'd5) begin
            push_word(f_addi(rd, rs1, imm));
        end else if (op == 4'd6) begin
            push_word(f_lui(rd, imm >> 12));
        end else if (op == 4'd7 || op == 4'd8) begin
            if ((s % 2) != 0 || s < -4096 || s > 4094) exp_err++;
            else begin
                w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 63) << 25) | (32'(rs2) << 20)
                    | (32'(rs1) << 15) | ((op == 4'd8) ? 32'h1000 : 32'h0)
                    | (((imm >> 1) & 15) << 8) | (((imm >> 11) & 1) << 7) | 32'h63;
                push_word(w);
            end
        end else if (op == 4'd9) begin
            if ((s % 2) != 0 || s < -1048576 || s > 1048574) exp_err++;
            else begin
                w = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 1023) << 21) | (((imm >> 11) & 1) << 20)
                    | (((imm >> 12) & 255) << 12) | (32'(rd) << 7) | 32'h6F;
                push_word(w);
            end
        end else if (op == 4'd10 && LI_EN) begin
            if (s >= -2048 && s <= 2047) push_word(f_addi(rd, 5'd0, imm));
            else begin
                push_word(f_lui(rd, (imm + 32'h800) >> 12));
                if ((imm & 32'hFFF) != 0) push_word(f_addi(rd, rd, imm));
            end
        end else begin
            exp_err++;
        end
    endtask

    function automatic logic [31:0] rand_imm();
        int v;
        case ($urandom_range(0, 4))
            0: v = int'($urandom());
            1: v = int'($urandom_range(0, 8200)) - 4100;
            2: v = int'($urandom_range(0, 4200)) - 2100;
            3: v = int'($urandom_range(0, 2100000)) - 1050000;
            default: v = bl[$urandom_range(0, 16)];
        endcase
        return 32'(v);
    endfunction

    // ---------------- drivers ----------------
    task automatic send(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm);
        int t;
        bus.req_op = op; bus.req_rd = rd; bus.req_rs1 = rs1; bus.req_rs2 = rs2; bus.req_imm = imm;
        bus.req_valid = 1'b1;
        model(op, rd, rs1, rs2, imm);
        t = 0;
        forever begin
            @(negedge clk);
            if (bus.req_ready === 1'b1) break;
            t++;
            if (t > 50) begin
                n_cmp++; n_bad++;
                $display("FAIL send_timeout op=%0d req_ready stuck at %b want 1", op, bus.req_ready);
                break;
            end
            @(posedge clk); #1;
            if (rand_bp) bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        if (rand_bp) bus.out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic drain();
        int t;
        rand_bp = 1'b0;
        bus.out_ready = 1'b1;
        t = 0;
        while (obs_instr.size() < exp_instr.size() && t < 60) begin
            @(posedge clk); #1;
            t++;
        end
        @(posedge clk); #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        bus.req_valid = 1'b1; bus.req_op = 4'd0; bus.req_rd = 5'd1; bus.req_rs1 = 5'd2;
        bus.req_rs2 = 5'd3; bus.req_imm = 32'd0; bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (bus.req_ready !== 1'b0) begin n_bad++; $display("FAIL reset_req_ready got %b want 0", bus.req_ready); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.out_instr !== 32'd0) begin n_bad++; $display("FAIL reset_out_instr got %08h want 0", bus.out_instr); end
        n_cmp++; if (bus.out_addr !== '0) begin n_bad++; $display("FAIL reset_out_addr got %0d want 0", bus.out_addr); end
        n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", bus.err); end
        bus.req_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (bus.out_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            n_bad++; $display("FAIL post_reset_idle got valid=%b ready=%b want valid=0 ready=1", bus.out_valid, bus.req_ready);
        end
    endtask

    task automatic test_rtype();
        time t0;
        bus.out_ready = 1'b1;
        send(4'd0, 5'd3, 5'd1, 5'd2, 32'd0);
        t0 = $time;
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'h002081B3 || bus.out_addr !== 2'd0) begin
            n_bad++; $display("FAIL add_word got v=%b %08h@%0d want v=1 002081b3@0", bus.out_valid, bus.out_instr, bus.out_addr);
        end
        send(4'd4, 5'd5, 5'd6, 5'd7, 32'd0);
        n_cmp++; if (bus.out_instr !== 32'h407302B3 || bus.out_addr !== 2'd1 || ($time - t0) != 10) begin
            n_bad++; $display("FAIL sub_b2b got %08h@%0d dt=%0t want 407302b3@1 dt=10", bus.out_instr, bus.out_addr, $time - t0);
        end
        for (int i = 0; i < 6; i++)
            send(4'($urandom_range(0, 4)), 5'($urandom), 5'($urandom), 5'($urandom), $urandom());
        drain();
        for (int k = seen; k < exp_instr.size(); k++) begin
            n_cmp++;
            if (k >= obs_instr.size()) begin n_bad++; $display("FAIL rtype_stream[%0d] got none want %08h@%0d", k, exp_instr[k], exp_addr[k]); end
            else if (obs_instr[k] !== exp_instr[k] || obs_addr[k] !== exp_addr[k]) begin
                n_bad++; $display("FAIL rtype_stream[%0d] got %08h@%0d want %08h@%0d", k, obs_instr[k], obs_addr[k], exp_instr[k], exp_addr[k]);
            end
        end
        seen = exp_instr.size();
        n_cmp++; if (obs_err != exp_err || obs_instr.size() != exp_instr.size()) begin
            n_bad++; $display("FAIL rtype_counts got err=%0d words=%0d want err=%0d words=%0d", obs_err, obs_instr.size(), exp_err, exp_instr.size());
        end
    endtask

    task automatic test_branch();
        bus.out_ready = 1'b1;
        send(4'd7, 5'd0, 5'd1, 5'd2, -32'sd8);
        n_cmp++; if (bus.out_instr !== 32'hFE208CE3) begin n_bad++; $display("FAIL beq_neg8 got %08h want fe208ce3", bus.out_instr); end
        send(4'd7, 5'd0, 5'd1, 5'd2, 32'd3);
        n_cmp++; if (bus.err !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_bad++; $display("FAIL beq_odd_err got err=%b valid=%b want err=1 valid=0", bus.err, bus.out_valid);
        end
        @(posedge clk); #1;
        n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL err_one_cycle got %b want 0", bus.err); end
        send(4'd8, 5'd0, 5'd4, 5'd5, 32'd16);
        for (int i = 0; i < 12; i++)
            send(4'($urandom_range(7, 9)), 5'($urandom), 5'($urandom), 5'($urandom), rand_imm());
        for (int i = 0; i < 8; i++)
            send(4'(7 + (i % 3)), 5'd1, 5'd2, 5'd3, 32'(bl[i]));
        drain();
        for (int k = seen; k < exp_instr.size(); k++) begin
            n_cmp++;
            if (k >= obs_instr.size()) begin n_bad++; $display("FAIL branch_stream[%0d] got none want %08h@%0d", k, exp_instr[k], exp_addr[k]); end
            else if (obs_instr[k] !== exp_instr[k] || obs_addr[k] !== exp_addr[k]) begin
                n_bad++; $display("FAIL branch_stream[%0d] got %08h@%0d want %08h@%0d", k, obs_instr[k], obs_addr[k], exp_instr[k], exp_addr[k]);
            end
        end
        seen = exp_instr.size();
        n_cmp++; if (obs_err != exp_err || obs_instr.size() != exp_instr.size()) begin
            n_bad++; $display("FAIL branch_counts got err=%0d words=%0d want err=%0d words=%0d", obs_err, obs_instr.size(), exp_err, exp_instr.size());
        end
    endtask

    task automatic test_li();
        bit ok;
        bit found;
        bus.out_ready = 1'b1;
`ifdef SR_ENC_LI_EN
        send(4'd10, 5'd1, 5'd0, 5'd0, 32'h12345FFF);
        n_cmp++; if (bus.out_instr !== 32'h123460B7) begin n_bad++; $display("FAIL li_lui got %08h want 123460b7", bus.out_instr); end
        ok = 1'b1; found = 1'b0;
        for (int c = 0; c < 8 && !found; c++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1 && bus.out_instr === 32'hFFF08093) found = 1'b1;
            else if (bus.req_ready !== 1'b0) ok = 1'b0;
        end
        @(posedge clk); #1;
        n_cmp++; if (!ok || !found) begin n_bad++; $display("FAIL li_second got found=%b ready_low=%b want 1 1", found, ok); end
        send(4'd10, 5'd2, 5'd0, 5'd0, 32'd5);
        n_cmp++; if (bus.out_instr !== 32'h00500113) begin n_bad++; $display("FAIL li_small got %08h want 00500113", bus.out_instr); end
        send(4'd10, 5'd2, 5'd0, 5'd0, 32'h1000);
        n_cmp++; if (bus.out_instr !== 32'h00001137) begin n_bad++; $display("FAIL li_lui_only got %08h want 00001137", bus.out_instr); end
`else
        send(4'd10, 5'd1, 5'd0, 5'd0, 32'h12345FFF);
        n_cmp++; if (bus.err !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_bad++; $display("FAIL li_disabled got err=%b valid=%b want err=1 valid=0", bus.err, bus.out_valid);
        end
`endif
        for (int i = 0; i < 12; i++)
            send(4'd10, 5'($urandom), 5'($urandom), 5'($urandom), rand_imm());
        drain();
        for (int k = seen; k < exp_instr.size(); k++) begin
            n_cmp++;
            if (k >= obs_instr.size()) begin n_bad++; $display("FAIL li_stream[%0d] got none want %08h@%0d", k, exp_instr[k], exp_addr[k]); end
            else if (obs_instr[k] !== exp_instr[k] || obs_addr[k] !== exp_addr[k]) begin
                n_bad++; $display("FAIL li_stream[%0d] got %08h@%0d want %08h@%0d", k, obs_instr[k], obs_addr[k], exp_instr[k], exp_addr[k]);
            end
        end
        seen = exp_instr.size();
        n_cmp++; if (obs_err != exp_err || obs_instr.size() != exp_instr.size()) begin
            n_bad++; $display("FAIL li_counts got err=%0d words=%0d want err=%0d words=%0d", obs_err, obs_instr.size(), exp_err, exp_instr.size());
        end
    endtask

    task automatic test_backpressure();
        logic [31:0]       hold_i;
        logic [ADDR_W-1:0] hold_a;
        bit stable;
        bus.out_ready = 1'b0;
        send(4'd5, 5'd4, 5'd3, 5'd9, 32'h7A5);
        hold_i = bus.out_instr;
        hold_a = bus.out_addr;
        n_cmp++; if (hold_i !== exp_instr[exp_instr.size()-1] || hold_a !== exp_addr[exp_addr.size()-1]) begin
            n_bad++; $display("FAIL bp_held got %08h@%0d want %08h@%0d", hold_i, hold_a,
                              exp_instr[exp_instr.size()-1], exp_addr[exp_addr.size()-1]);
        end
        bus.req_op = 4'd1; bus.req_rd = 5'd8; bus.req_rs1 = 5'd9; bus.req_rs2 = 5'd10; bus.req_imm = 32'd0;
        bus.req_valid = 1'b1;
        model(4'd1, 5'd8, 5'd9, 5'd10, 32'd0);
        stable = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (!(bus.out_valid === 1'b1 && bus.out_instr === hold_i && bus.out_addr === hold_a && bus.req_ready === 1'b0))
                stable = 1'b0;
            @(posedge clk); #1;
        end
        n_cmp++; if (!stable) begin n_bad++; $display("FAIL bp_stable got unstable/ready want held and ready=0"); end
        bus.out_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release_ready got %b want 1", bus.req_ready); end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_instr !== exp_instr[exp_instr.size()-1]) begin
            n_bad++; $display("FAIL bp_next_word got v=%b %08h want v=1 %08h", bus.out_valid, bus.out_instr, exp_instr[exp_instr.size()-1]);
        end
        drain();
        for (int k = seen; k < exp_instr.size(); k++) begin
            n_cmp++;
            if (k >= obs_instr.size()) begin n_bad++; $display("FAIL bp_stream[%0d] got none want %08h@%0d", k, exp_instr[k], exp_addr[k]); end
            else if (obs_instr[k] !== exp_instr[k] || obs_addr[k] !== exp_addr[k]) begin
                n_bad++; $display("FAIL bp_stream[%0d] got %08h@%0d want %08h@%0d", k, obs_instr[k], obs_addr[k], exp_instr[k], exp_addr[k]);
            end
        end
        seen = exp_instr.size();
    endtask

    task automatic test_illegal_wrap();
        int base;
        logic [ADDR_W-1:0] want_a [0:4] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        bus.out_ready = 1'b1;
        send(4'd13, 5'd1, 5'd2, 5'd3, 32'd0);
        n_cmp++; if (bus.err !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_bad++; $display("FAIL illegal_op got err=%b valid=%b want err=1 valid=0", bus.err, bus.out_valid);
        end
        while (exp_next != 0) send(4'd5, 5'd1, 5'd1, 5'd0, 32'd1);
        drain();
        base = exp_instr.size();
        for (int i = 0; i < 5; i++) send(4'd5, 5'(i + 1), 5'd0, 5'd0, 32'(i * 3));
        drain();
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (base + i >= obs_addr.size() || obs_addr[base + i] !== want_a[i]) begin
                n_bad++; $display("FAIL wrap_addr[%0d] got %0d want %0d", i,
                                  (base + i < obs_addr.size()) ? int'(obs_addr[base + i]) : -1, want_a[i]);
            end
        end
        for (int k = seen; k < exp_instr.size(); k++) begin
            n_cmp++;
            if (k >= obs_instr.size()) begin n_bad++; $display("FAIL wrap_stream[%0d] got none want %08h@%0d", k, exp_instr[k], exp_addr[k]); end
            else if (obs_instr[k] !== exp_instr[k] || obs_addr[k] !== exp_addr[k]) begin
                n_bad++; $display("FAIL wrap_stream[%0d] got %08h@%0d want %08h@%0d", k, obs_instr[k], obs_addr[k], exp_instr[k], exp_addr[k]);
            end
        end
        seen = exp_instr.size();
        n_cmp++; if (obs_err != exp_err) begin n_bad++; $display("FAIL wrap_err_count got %0d want %0d", obs_err, exp_err); end
    endtask

    task automatic test_random();
        rand_bp = 1'b1;
        for (int i = 0; i < 60; i++)
            send(4'($urandom_range(0, 15)), 5'($urandom), 5'($urandom), 5'($urandom), rand_imm());
        drain();
        for (int k = seen; k < exp_instr.size(); k++) begin
            n_cmp++;
            if (k >= obs_instr.size()) begin n_bad++; $display("FAIL rand_stream[%0d] got none want %08h@%0d", k, exp_instr[k], exp_addr[k]); end
            else if (obs_instr[k] !== exp_instr[k] || obs_addr[k] !== exp_addr[k]) begin
                n_bad++; $display("FAIL rand_stream[%0d] got %08h@%0d want %08h@%0d", k, obs_instr[k], obs_addr[k], exp_instr[k], exp_addr[k]);
            end
        end
        seen = exp_instr.size();
        n_cmp++; if (obs_err != exp_err || obs_instr.size() != exp_instr.size()) begin
            n_bad++; $display("FAIL rand_counts got err=%0d words=%0d want err=%0d words=%0d", obs_err, obs_instr.size(), exp_err, exp_instr.size());
        end
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b1;
`ifdef SR_ENC_LI_EN
        while (exp_next == 3) begin send(4'd5, 5'd1, 5'd0, 5'd0, 32'd2); drain(); end
        bus.out_ready = 1'b0;
        send(4'd10, 5'd1, 5'd0, 5'd0, 32'h12345FFF);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
`else
        while (exp_next == 0) begin send(4'd5, 5'd1, 5'd0, 5'd0, 32'd2); drain(); end
        bus.out_ready = 1'b0;
        send(4'd5, 5'd6, 5'd7, 5'd0, 32'h123);
`endif
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0 || bus.out_addr !== '0 || bus.req_ready !== 1'b0) begin
            n_bad++; $display("FAIL reset_mid got valid=%b addr=%0d ready=%b want 0 0 0", bus.out_valid, bus.out_addr, bus.req_ready);
        end
        while (exp_instr.size() > obs_instr.size()) begin
            void'(exp_instr.pop_back());
            void'(exp_addr.pop_back());
        end
        exp_next = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        send(4'd5, 5'd9, 5'd0, 5'd0, 32'h0AB);
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_addr !== '0 || bus.out_instr !== 32'h0AB00493) begin
            n_bad++; $display("FAIL after_reset_word got v=%b %08h@%0d want v=1 0ab00493@0", bus.out_valid, bus.out_instr, bus.out_addr);
        end
        drain();
        for (int k = seen; k < exp_instr.size(); k++) begin
            n_cmp++;
            if (k >= obs_instr.size()) begin n_bad++; $display("FAIL rstmid_stream[%0d] got none want %08h@%0d", k, exp_instr[k], exp_addr[k]); end
            else if (obs_instr[k] !== exp_instr[k] || obs_addr[k] !== exp_addr[k]) begin
                n_bad++; $display("FAIL rstmid_stream[%0d] got %08h@%0d want %08h@%0d", k, obs_instr[k], obs_addr[k], exp_instr[k], exp_addr[k]);
            end
        end
        seen = exp_instr.size();
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_branch();
        test_li();
        test_backpressure();
        test_illegal_wrap();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sr_instr_encoder.md
# sr_instr_encoder

Instruction encoder for the schoolRISCV test infrastructure: accepts symbolic instruction requests (operation, register indices, immediate) over a valid/ready handshake. It emits 32-bit RV32I machine words with their word addresses, ready for the instruction-memory write port. It covers the exact instruction subset the single-cycle CPU decodes, plus an optional `li` pseudo-instruction that expands to one or two words. It sits between a program-generator/bench front end and instruction memory.

## Interface
- `ADDR_W`, default 10: width of the emitted word-address counter.

- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `req_valid`  in  1  request present
- `req_ready`  out  1  request accepted when `req_valid & req_ready`
- `req_op`  in  4  0 ADD, 1 OR, 2 SRL, 3 SLTU, 4 SUB, 5 ADDI, 6 LUI, 7 BEQ, 8 BNE, 9 JAL, 10 LI; 11–15 illegal
- `req_rd`  in  5  destination register
- `req_rs1`  in  5  source 1
- `req_rs2`  in  5  source 2
- `req_imm`  in  32  immediate: ADDI/LI value; LUI uses bits [31:12]; BEQ/BNE/JAL byte offset
- `out_valid`  out  1  `out_instr` valid
- `out_ready`  in  1  consumer takes word when `out_valid & out_ready`
- `out_instr`  out  32  encoded machine word
- `out_addr`  out  ADDR_W  word address of `out_instr`
- `err`  out  1  one-cycle pulse: request rejected

## Operation
- **Encodings:**
  - R-type (opcode `0110011`): f3 is ADD `000`, OR `110`, SRL `101`, SLTU `011`, SUB `000`; f7 is `0100000` for SUB and `0` otherwise.
  - ADDI: opcode `0010011`, f3 `000`, imm[11:0].
  - LUI: opcode `0110111`, imm[31:12].
  - BEQ/BNE: opcode `1100011`, f3 `000`/`001`, B-format imm[12:1].
  - JAL: opcode `1101111`, J-format imm[20:1].
- **Unused fields:** unused register fields are encoded as 0. For example, the rs2 field is 0 for ADDI.
- **Errors:** any of the following causes the request to be consumed with no word emitted. `err` pulses the cycle after acceptance and `out_addr` does not advance.
  - illegal op
  - BEQ/BNE offset odd or outside [-4096, 4094]
  - JAL offset odd or outside [-1048576, 1048574]
- **LI expansion:** let `lo = imm[11:0]` sign-extended and `hi = (imm + 0x800) >> 12`, truncated to 20 bits.
  - If `imm` is in [-2048, 2047]: emit a single `ADDI rd, x0, lo`.
  - Otherwise emit `LUI rd, hi`, followed by `ADDI rd, rd, lo` only when `lo != 0`.
- **FSM states:**
  - IDLE: output register empty or draining.
  - EMIT: holding a word.
  - EMIT2: holding a pending second LI word.
- **FSM transitions:**
  - IDLE → EMIT on any legal accepted request.
  - EMIT → EMIT2 on the first-word handshake of a two-word LI.
  - EMIT2 → EMIT on the cycle it loads the ADDI word.
  - EMIT → IDLE on handshake, or stay in EMIT if a new request is accepted in the same cycle.
- **Address counter:** `out_addr` increments by 1 on every output handshake and wraps modulo 2^ADDR_W.

## Timing
- **Reset values:** `req_ready`=0 during reset; after reset `out_valid`=0, `out_instr`=0, `out_addr`=0, `err`=0, state IDLE.
- **Latency:** a request accepted in cycle N presents its word in cycle N+1. `err` is also registered, so it pulses in cycle N+1.
- **`req_ready`:** equals `(!out_valid | out_ready)` and not in EMIT2, and not while a two-word LI still owes its second word.
- **Throughput:** one word per cycle under continuous `out_ready`. A two-word LI blocks requests for one extra cycle.
- **Backpressure:** `out_valid` is held until handshake. `out_instr` and `out_addr` stay stable while `out_valid & !out_ready`.
- **Error timing:** an errored request still frees `req_ready` the following cycle.
- **Reset mid-operation:** asynchronous reset drops any held or pending word, and the counter returns to 0.

## Configuration
- `SR_ENC_LI_EN` defined: op 10 (LI) is legal and expands as described.
- `SR_ENC_LI_EN` undefined: op 10 is illegal (`err` pulse, no word). EMIT2 is not built, so `req_ready` depends only on the output register.

## Test plan
- **R-type:** ADD rd=3 rs1=1 rs2=2 → `0x002081B3` @ addr 0; then SUB rd=5 rs1=6 rs2=7 → `0x407302B3` @ addr 1, on back-to-back cycles.
- **BEQ offset:** BEQ rs1=1 rs2=2 imm=-8 → `0xFE208CE3`. BEQ imm=3 → `err` pulse, no `out_valid`, next word still gets the next address.
- **LI (requires `SR_ENC_LI_EN`):**
  - rd=1 imm=`0x12345FFF` → `0x123460B7`, then `0xFFF08093`, with `req_ready` low until the second handshake.
  - rd=2 imm=5 → `0x00500113` only.
  - rd=2 imm=`0x1000` → `0x00001137` only.
- **Backpressure:** hold `out_ready`=0 for 3 cycles with a word held → `out_instr`/`out_addr` stable and `req_ready`=0. Release it → handshake, and the next request is accepted in the same cycle.
- **Illegal op and wrap:** op 13 → `err` pulse. With ADDR_W=2, five ADDI words → addresses 0, 1, 2, 3, 0.
- **Reset mid-operation:** assert `rst_n`=0 during EMIT2 → `out_valid`=0, `out_addr`=0 immediately. After release, first word at addr 0.
